rv_encode_instr: RTL and testbench

- Sequential RV32I instruction encoder: the inverse of the instruction decoder.
- Accepts decoded fields (opcode, rd, rs1, rs2, funct3, funct7, full-width immediate) over a valid/ready handshake and emits packed 32-bit instruction words over a second valid/ready handshake.
- Validates the immediate, drops illegal requests and counts them.
- Sits between the test-program generator / boot loader and instruction memory; tags each emitted word with its load address.

---
 rtl/rv_encode_instr.sv | 163 ++++++++++++++++
 tb/tb_rv_encode_instr.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/rv_encode_instr.sv
// rv_encode_instr: sequential RV32I instruction encoder.
// Packs decoded fields into 32-bit instruction words behind a valid/ready
// handshake. Illegal requests are consumed without producing a word; each
// drop is flagged, classified and counted. Every emitted word carries its
// load address, which advances by 4 only on legal words.
module rv_encode_instr #(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int          ERR_CNT_W = 8
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 req_valid_i,
    output logic                 req_ready,
    input  logic [6:0]           opcode_i,
    input  logic [4:0]           rd_i,
    input  logic [4:0]           rs1_i,
    input  logic [4:0]           rs2_i,
    input  logic [2:0]           funct3_i,
    input  logic [6:0]           funct7_i,
    input  logic [31:0]          imm_i,
    output logic                 instr_valid,
    input  logic                 instr_ready_i,
    output logic [31:0]          instr,
    output logic [31:0]          addr,
    output logic                 err,
    output logic [1:0]           err_code,
    output logic [ERR_CNT_W-1:0] err_cnt
);

    // Opcode values that select each instruction format.
    localparam logic [6:0] OP_R = 7'h33;
    localparam logic [6:0] OP_I = 7'h13;
    localparam logic [6:0] OP_S = 7'h23;
    localparam logic [6:0] OP_B = 7'h63;
    localparam logic [6:0] OP_U = 7'h37;
    localparam logic [6:0] OP_J = 7'h6F;

    localparam logic [ERR_CNT_W-1:0] CNT_ONE = 1;

    typedef enum logic [2:0] {
        FMT_R,
        FMT_I,
        FMT_S,
        FMT_B,
        FMT_U,
        FMT_J,
        FMT_NONE
    } fmt_e;

    typedef enum logic [1:0] {
        ERR_NONE   = 2'd0,
        ERR_OPCODE = 2'd1,
        ERR_RANGE  = 2'd2,
        ERR_ALIGN  = 2'd3
    } err_e;

    fmt_e        fmt;
    err_e        chk;
    logic [31:0] enc;
    logic [31:0] next_addr;
    logic        accept;
    logic        beat_done;
    logic        fits_12;
    logic        fits_13;
    logic        fits_21;

    assign req_ready = !instr_valid || instr_ready_i;
    assign accept    = req_valid_i && req_ready;
    assign beat_done = instr_valid && instr_ready_i;

    // Signed-range checks: a value fits in N bits when every bit from N-1
    // upward is a copy of the sign bit. B/J evenness is checked separately,
    // so the top of each range (4094, 1048574) falls out naturally.
    assign fits_12 = (imm_i[31:11] == '0) || (imm_i[31:11] == '1);
    assign fits_13 = (imm_i[31:12] == '0) || (imm_i[31:12] == '1);
    assign fits_21 = (imm_i[31:20] == '0) || (imm_i[31:20] == '1);

    // Map the opcode onto its instruction format.
    always_comb begin
        // NOTE: every combinational output gets a default first so that no
        // path through the block leaves it unassigned and infers a latch.
        fmt = FMT_NONE;
        unique case (opcode_i)
            OP_R:    fmt = FMT_R;
            OP_I:    fmt = FMT_I;
            OP_S:    fmt = FMT_S;
            OP_B:    fmt = FMT_B;
            OP_U:    fmt = FMT_U;
            OP_J:    fmt = FMT_J;
            default: fmt = FMT_NONE;
        endcase
    end

    // Legality checks in priority order: opcode, alignment, then range.
    always_comb begin
        chk = ERR_NONE;
        if (fmt == FMT_NONE) begin
            chk = ERR_OPCODE;
        end else if (((fmt == FMT_B || fmt == FMT_J) && imm_i[0]) ||
                     (fmt == FMT_U && imm_i[11:0] != 12'h000)) begin
            chk = ERR_ALIGN;
        end else if (((fmt == FMT_I || fmt == FMT_S) && !fits_12) ||
                     (fmt == FMT_B && !fits_13) ||
                     (fmt == FMT_J && !fits_21)) begin
            chk = ERR_RANGE;
        end
    end

    // Pack the fields according to the selected format.
    always_comb begin
        enc = 32'h0;
        case (fmt)
            FMT_R: enc = {funct7_i, rs2_i, rs1_i, funct3_i, rd_i, opcode_i};
            FMT_I: enc = {imm_i[11:0], rs1_i, funct3_i, rd_i, opcode_i};
            FMT_S: enc = {imm_i[11:5], rs2_i, rs1_i, funct3_i, imm_i[4:0], opcode_i};
            FMT_B: enc = {imm_i[12], imm_i[10:5], rs2_i, rs1_i, funct3_i,
                          imm_i[4:1], imm_i[11], opcode_i};
            FMT_U: enc = {imm_i[31:12], rd_i, opcode_i};
            FMT_J: enc = {imm_i[20], imm_i[10:1], imm_i[11], imm_i[19:12],
                          rd_i, opcode_i};
            default: enc = 32'h0;
        endcase
    end

    // Output word, address tagging and error reporting registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        // NOTE: every register here is small control/data state, so all of it
        // is reset; a pending word is discarded immediately on reset.
        if (!rst_ni) begin
            instr_valid <= 1'b0;
            instr       <= 32'h0;
            addr        <= BASE_ADDR;
            next_addr   <= BASE_ADDR;
            err         <= 1'b0;
            err_code    <= ERR_NONE;
            err_cnt     <= '0;
        end else begin
            // NOTE: non-blocking assignments keep every register update in
            // this block based on pre-edge values, independent of order.
            err <= 1'b0;
            if (accept && chk == ERR_NONE) begin
                instr_valid <= 1'b1;
                instr       <= enc;
                addr        <= next_addr;
                next_addr   <= next_addr + 32'd4;
            end else begin
                if (accept) begin
                    err      <= 1'b1;
                    err_code <= chk;
                    if (err_cnt != '1) begin
                        err_cnt <= err_cnt + CNT_ONE;
                    end
                end
                // An accepted illegal request implies req_ready, so the
                // current word (if any) is completing and valid drops.
                if (beat_done) begin
                    instr_valid <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_rv_encode_instr.sv
// Directed self-checking bench for rv_encode_instr with hand-computed words.
module tb_rv_encode_instr;

    logic        clk_i;
    logic        rst_ni;
    logic        req_valid_i;
    logic        req_ready;
    logic [6:0]  opcode_i;
    logic [4:0]  rd_i;
    logic [4:0]  rs1_i;
    logic [4:0]  rs2_i;
    logic [2:0]  funct3_i;
    logic [6:0]  funct7_i;
    logic [31:0] imm_i;
    logic        instr_valid;
    logic        instr_ready_i;
    logic [31:0] instr;
    logic [31:0] addr;
    logic        err;
    logic [1:0]  err_code;
    logic [7:0]  err_cnt;

    int errors = 0;
    int checks = 0;

    rv_encode_instr #(
        .BASE_ADDR(32'h0000_0000),
        .ERR_CNT_W(8)
    ) dut (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .req_valid_i  (req_valid_i),
        .req_ready    (req_ready),
        .opcode_i     (opcode_i),
        .rd_i         (rd_i),
        .rs1_i        (rs1_i),
        .rs2_i        (rs2_i),
        .funct3_i     (funct3_i),
        .funct7_i     (funct7_i),
        .imm_i        (imm_i),
        .instr_valid  (instr_valid),
        .instr_ready_i(instr_ready_i),
        .instr        (instr),
        .addr         (addr),
        .err          (err),
        .err_code     (err_code),
        .err_cnt      (err_cnt)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [31:0] observed,
                         input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic set_req(input logic [6:0] op, input logic [4:0] rd,
                           input logic [4:0] rs1, input logic [4:0] rs2,
                           input logic [2:0] f3, input logic [6:0] f7,
                           input logic [31:0] imm);
        opcode_i    = op;
        rd_i        = rd;
        rs1_i       = rs1;
        rs2_i       = rs2;
        funct3_i    = f3;
        funct7_i    = f7;
        imm_i       = imm;
        req_valid_i = 1'b1;
    endtask

    task automatic check_word(input string tag, input logic [31:0] exp_instr,
                              input logic [31:0] exp_addr);
        check({tag, "_valid"}, 32'(instr_valid), 32'd1);
        check({tag, "_instr"}, instr, exp_instr);
        check({tag, "_addr"}, addr, exp_addr);
    endtask

    task automatic check_drop(input string tag, input logic [1:0] code,
                              input logic [7:0] cnt);
        check({tag, "_valid"}, 32'(instr_valid), 32'd0);
        check({tag, "_err"}, 32'(err), 32'd1);
        check({tag, "_code"}, 32'(err_code), 32'(code));
        check({tag, "_cnt"}, 32'(err_cnt), 32'(cnt));
    endtask

    initial begin
        rst_ni        = 1'b0;
        req_valid_i   = 1'b0;
        instr_ready_i = 1'b1;
        opcode_i      = 7'h00;
        rd_i          = 5'd0;
        rs1_i         = 5'd0;
        rs2_i         = 5'd0;
        funct3_i      = 3'd0;
        funct7_i      = 7'd0;
        imm_i         = 32'h0;

        // Reset state
        repeat (2) tick();
        check("rst_valid", 32'(instr_valid), 32'd0);
        check("rst_instr", instr, 32'h0);
        check("rst_addr", addr, 32'h0);
        check("rst_err", 32'(err), 32'd0);
        check("rst_code", 32'(err_code), 32'd0);
        check("rst_cnt", 32'(err_cnt), 32'd0);
        check("rst_ready", 32'(req_ready), 32'd1);
        #3 rst_ni = 1'b1;
        tick();

        // Legal back-to-back sequence, one word per cycle
        set_req(7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5);          // ADDI x1,x0,5
        tick();
        check_word("addi", 32'h0050_0093, 32'h0);
        set_req(7'h23, 5'd0, 5'd1, 5'd2, 3'd2, 7'd0, 32'd8);          // SW x2,8(x1)
        tick();
        check_word("sw", 32'h0020_A423, 32'h4);
        set_req(7'h33, 5'd3, 5'd1, 5'd2, 3'd0, 7'd0, 32'd0);          // ADD x3,x1,x2
        tick();
        check_word("add", 32'h0020_81B3, 32'h8);
        set_req(7'h63, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFFF_FFFC);  // BEQ x0,x0,-4
        tick();
        check_word("beq", 32'hFE00_0EE3, 32'hC);
        set_req(7'h6F, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd8);          // JAL x1,8
        tick();
        check_word("jal", 32'h0080_00EF, 32'h10);
        set_req(7'h37, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'h1234_5000);  // LUI x5
        tick();
        check_word("lui", 32'h1234_52B7, 32'h14);
        req_valid_i = 1'b0;
        tick();
        check("idle_valid", 32'(instr_valid), 32'd0);

        // Backpressure: word held stable, request stalled
        instr_ready_i = 1'b0;
        set_req(7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5);
        tick();
        check_word("bp_first", 32'h0050_0093, 32'h18);
        set_req(7'h23, 5'd0, 5'd1, 5'd2, 3'd2, 7'd0, 32'd8);
        for (int i = 0; i < 3; i++) begin
            check("bp_ready", 32'(req_ready), 32'd0);
            tick();
            check_word("bp_hold", 32'h0050_0093, 32'h18);
        end
        instr_ready_i = 1'b1;
        #1;
        check("bp_release_ready", 32'(req_ready), 32'd1);
        tick();
        check_word("bp_next", 32'h0020_A423, 32'h1C);
        req_valid_i = 1'b0;
        tick();
        check("bp_drain", 32'(instr_valid), 32'd0);

        // Illegal requests
        set_req(7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd2048);       // ADDI imm=2048
        tick();
        check_drop("ill_range", 2'd2, 8'd1);
        req_valid_i = 1'b0;
        tick();
        check("err_pulse_end", 32'(err), 32'd0);
        check("err_code_held", 32'(err_code), 32'd2);
        set_req(7'h63, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd3);          // BEQ imm=3
        tick();
        check_drop("ill_align", 2'd3, 8'd2);
        set_req(7'h7F, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd0);          // unknown opcode
        tick();
        check_drop("ill_opcode", 2'd1, 8'd3);
        set_req(7'h33, 5'd3, 5'd1, 5'd2, 3'd0, 7'd0, 32'd0);          // ADD after drops
        tick();
        check_word("post_drop", 32'h0020_81B3, 32'h20);
        set_req(7'h37, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'h1234_5001);  // LUI misaligned
        tick();
        check_drop("ill_u_align", 2'd3, 8'd4);

        // Immediate range boundaries
        set_req(7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd2047);
        tick();
        check_word("imm_max", 32'h7FF0_0093, 32'h24);
        set_req(7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFFF_F800);  // -2048
        tick();
        check_word("imm_min", 32'h8000_0093, 32'h28);
        set_req(7'h6F, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'h0010_0000);  // JAL 1048576
        tick();
        check_drop("ill_j_range", 2'd2, 8'd5);

        // Counter saturation
        set_req(7'h7F, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd0);
        repeat (249) tick();
        check("sat_254", 32'(err_cnt), 32'd254);
        repeat (51) tick();
        check("sat_255", 32'(err_cnt), 32'd255);
        check("sat_code", 32'(err_code), 32'd1);
        req_valid_i = 1'b0;
        tick();

        // Async reset with a word pending
        instr_ready_i = 1'b0;
        set_req(7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5);
        tick();
        check_word("pre_reset", 32'h0050_0093, 32'h2C);
        req_valid_i = 1'b0;
        #2 rst_ni = 1'b0;
        #1;
        check("areset_valid", 32'(instr_valid), 32'd0);
        check("areset_cnt", 32'(err_cnt), 32'd0);
        check("areset_addr", addr, 32'h0);
        tick();
        #2 rst_ni = 1'b1;
        instr_ready_i = 1'b1;
        tick();
        set_req(7'h33, 5'd3, 5'd1, 5'd2, 3'd0, 7'd0, 32'd0);
        tick();
        check_word("post_reset", 32'h0020_81B3, 32'h0);
        req_valid_i = 1'b0;
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
